// File: rtl/test_result_checker.sv
// test_result_checker: end-of-program checker that waits for the halt PC, then reads the answer region and compares it to a golden store.
//   Optional feature macro: CHK_HALT_REG_EN adds the halt_reg input and the HALT_REG_EXP parameter.
//   Ports:
//     clk, rst          clock and asynchronous active-high reset
//     current_pc        retiring PC, qualified by pc_valid
//     gold_we/idx/data  golden store write port (accepted only while running)
//     mem_req/mem_addr  single-outstanding read request (one-cycle pulse) and byte address
//     mem_rdata/rvalid  read response, used only while waiting
//     busy              check phase in progress
//     done              sticky, result final
//     pass              valid with done
//     timeout           sticky, cycle limit reached
//     err_count         mismatches (saturating)
//     first_err_idx     word index of the first mismatch
//     first_err_data    memory value of the first mismatch
//     halt_reg          (CHK_HALT_REG_EN) register value sampled at halt
module test_result_checker #(
  parameter int XLEN = 64,
  parameter int ADDR_W = 32,
  parameter int NUM_WORDS = 32,
  parameter logic [ADDR_W-1:0] ANSWER_BASE = 'h9000,
  parameter logic [XLEN-1:0] HALT_PC = 'h1c,
  parameter int MAX_CYCLES = 400000,
  parameter int ERR_W = 16
`ifdef CHK_HALT_REG_EN
  ,
  parameter logic [XLEN-1:0] HALT_REG_EXP = '0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic [XLEN-1:0] current_pc,
  input  logic pc_valid,
  input  logic gold_we,
  input  logic [(NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1)-1:0] gold_idx,
  input  logic [XLEN-1:0] gold_data,
  output logic mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic mem_rvalid,
`ifdef CHK_HALT_REG_EN
  input  logic [XLEN-1:0] halt_reg,
`endif
  output logic busy,
  output logic done,
  output logic pass,
  output logic timeout,
  output logic [ERR_W-1:0] err_count,
  output logic [(NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1)-1:0] first_err_idx,
  output logic [XLEN-1:0] first_err_data
);
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int CW = MAX_CYCLES > 1 ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_CYCLES - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] REQ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic hit;
  logic halt_bad;
  logic [XLEN-1:0] gold [NUM_WORDS];
  logic halt, limit, miss;
  assign halt = pc_valid && current_pc == HALT_PC;
  // counter saturates at the limit, so a halt that wins on the limit cycle still times out right after
  assign limit = cnt == LIM;
  assign miss = mem_rdata != gold[idx];
  assign mem_req = state == REQ;
  assign busy = state == REQ || state == WAIT;
  assign done = state == DONE;
  // address is gated so every output reads 0 in reset
  assign mem_addr = mem_req ? ANSWER_BASE + ADDR_W'(idx) * ADDR_W'(XLEN / 8) : '0;
  assign pass = done && !timeout && err_count == '0 && !halt_bad;
  always_ff @(posedge clk)
    if (gold_we && state == RUN && {1'b0, gold_idx} < (IW + 1)'(NUM_WORDS)) gold[gold_idx] <= gold_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      idx <= '0;
      cnt <= '0;
      hit <= 1'b0;
      halt_bad <= 1'b0;
      timeout <= 1'b0;
      err_count <= '0;
      first_err_idx <= '0;
      first_err_data <= '0;
    end else begin
      if (state != DONE && !limit) cnt <= cnt + CW'(1);
      case (state)
        RUN:
          if (halt) begin
            state <= REQ;
            idx <= '0;
`ifdef CHK_HALT_REG_EN
            halt_bad <= halt_reg != HALT_REG_EXP;
            if (halt_reg != HALT_REG_EXP) err_count <= ERR_W'(1);
`endif
          end else if (limit) begin
            state <= DONE;
            timeout <= 1'b1;
          end
        REQ: begin
          state <= limit ? DONE : WAIT;
          timeout <= limit;
        end
        WAIT:
          if (limit) begin
            state <= DONE;
            timeout <= 1'b1;
          end else if (mem_rvalid) begin
            if (miss) begin
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
              if (!hit) begin
                hit <= 1'b1;
                first_err_idx <= idx;
                first_err_data <= mem_rdata;
              end
            end
            if (idx == LAST) state <= DONE;
            else begin
              idx <= idx + IW'(1);
              state <= REQ;
            end
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_test_result_checker.sv
// tb_test_result_checker: directed self-checking bench with a latency-programmable memory responder.
module tb_test_result_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] current_pc = '0;
  logic pc_valid = 1'b0;
  logic gold_we = 1'b0;
  logic [4:0] gold_idx = '0;
  logic [63:0] gold_data = '0;
  logic mem_req;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  logic mem_rvalid = 1'b0;
  logic [63:0] halt_reg = '0;
  logic busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [4:0] first_err_idx;
  logic [63:0] first_err_data;
  int errors = 0;
  int checks = 0;
  int lat = 1;
  bit spur = 0;
  bit bad = 0;
  int pend = 0;
  int k = 0;
  int reqs = 0;
  int addr_bad = 0;
  int overlap = 0;
  logic [31:0] paddr = '0;
  int base, abase, n;
  always #5 clk = ~clk;
  test_result_checker #(.MAX_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .current_pc(current_pc), .pc_valid(pc_valid),
    .gold_we(gold_we), .gold_idx(gold_idx), .gold_data(gold_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
`ifdef CHK_HALT_REG_EN
    .halt_reg(halt_reg),
`endif
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data)
  );
  function automatic logic [63:0] word(input logic [31:0] a);
    int w;
    w = int'((a - 32'h9000) >> 3);
    if (bad && w == 5) return 64'hDEAD;
    if (bad && w == 9) return 64'h0;
    return 64'(w * 3);
  endfunction
  // responder and request monitor, run on the falling edge so DUT outputs are stable
  always @(negedge clk)
    if (rst) begin
      pend = 0;
      k = 0;
      mem_rvalid = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = word(paddr);
        end
      end
      if (mem_req) begin
        if (pend > 0) overlap++;
        if (mem_addr != 32'h9000 + 32'(8 * k)) addr_bad++;
        k++;
        reqs++;
        paddr = mem_addr;
        pend = lat;
        if (spur) begin
          mem_rvalid = 1'b1;
          mem_rdata = 64'hBAD;
        end
      end
    end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 64'(mem_req), 0);
    chk({tag, "_addr"}, 64'(mem_addr), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_pass"}, 64'(pass), 0);
    chk({tag, "_tmo"}, 64'(timeout), 0);
    chk({tag, "_err"}, 64'(err_count), 0);
    chk({tag, "_fidx"}, 64'(first_err_idx), 0);
    chk({tag, "_fdata"}, first_err_data, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic do_halt();
    pc_valid = 1'b1;
    current_pc = 64'h1c;
    step();
    pc_valid = 1'b0;
    current_pc = '0;
  endtask
  task automatic wait_done(input int bound, output int cnt);
    cnt = 0;
    while (!done && cnt < bound) begin
      step();
      cnt++;
    end
    chk("done_in_time", 64'(done), 1);
  endtask
  initial begin
    #1;
    chk_zero("rst0");
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      gold_we = 1'b1;
      gold_idx = 5'(i);
      gold_data = 64'(i * 3);
      step();
    end
    gold_we = 1'b0;
    pc_valid = 1'b1;
    current_pc = 64'h18;
    step();
    pc_valid = 1'b0;
    current_pc = 64'h1c;
    step();
    current_pc = '0;
    chk("no_false_halt", 64'(busy), 0);
    repeat (65) step();
    base = reqs;
    abase = addr_bad;
    do_halt();
    chk("t1_busy", 64'(busy), 1);
    wait_done(200, n);
    chk("t1_latency", 64'(n + 1), 65);
    chk("t1_reqs", 64'(reqs - base), 32);
    chk("t1_addr", 64'(addr_bad - abase), 0);
    chk("t1_pass", 64'(pass), 1);
    chk("t1_err", 64'(err_count), 0);
    chk("t1_tmo", 64'(timeout), 0);
    chk("t1_busy_end", 64'(busy), 0);
    // second run: golden retained across reset, two corrupted words
    do_reset();
    chk_zero("t2_rst");
    bad = 1;
    repeat (3) step();
    do_halt();
    wait_done(200, n);
    chk("t2_err", 64'(err_count), 2);
    chk("t2_fidx", 64'(first_err_idx), 5);
    chk("t2_fdata", first_err_data, 64'hDEAD);
    chk("t2_pass", 64'(pass), 0);
    chk("t2_tmo", 64'(timeout), 0);
    bad = 0;
    // slow memory with a spurious pulse on every request, plus a golden write while busy
    do_reset();
    lat = 7;
    spur = 1;
    base = reqs;
    do_halt();
    repeat (3) step();
    gold_we = 1'b1;
    gold_idx = 5'd31;
    gold_data = 64'hFFFF;
    step();
    gold_we = 1'b0;
    wait_done(600, n);
    chk("t3_reqs", 64'(reqs - base), 32);
    chk("t3_overlap", 64'(overlap), 0);
    chk("t3_err", 64'(err_count), 0);
    chk("t3_pass", 64'(pass), 1);
    lat = 1;
    spur = 0;
    // abort during the wait of word 12, then restart
    do_reset();
    base = reqs;
    do_halt();
    n = 0;
    while (reqs - base < 13 && n < 100) begin
      step();
      n++;
    end
    chk("t4_reached", 64'(reqs - base), 13);
    step();
    chk("t4_busy_pre", 64'(busy), 1);
    rst = 1'b1;
    #1;
    chk_zero("t4_abort");
    step();
    rst = 1'b0;
    base = reqs;
    do_halt();
    wait_done(200, n);
    chk("t4_reqs", 64'(reqs - base), 32);
    chk("t4_pass", 64'(pass), 1);
    chk("t4_addr", 64'(addr_bad - abase), 0);
    // no halt at all
    do_reset();
    base = reqs;
    wait_done(1100, n);
    chk("t5_cycles", 64'(n), 1000);
    chk("t5_tmo", 64'(timeout), 1);
    chk("t5_pass", 64'(pass), 0);
    chk("t5_reqs", 64'(reqs - base), 0);
    // halt on the very cycle the limit is reached
    do_reset();
    repeat (999) step();
    base = reqs;
    do_halt();
    chk("t6_busy", 64'(busy), 1);
    chk("t6_req", 64'(mem_req), 1);
    chk("t6_done", 64'(done), 0);
    step();
    chk("t6_done2", 64'(done), 1);
    chk("t6_tmo", 64'(timeout), 1);
    chk("t6_pass", 64'(pass), 0);
    chk("t6_reqs", 64'(reqs - base), 1);
`ifdef CHK_HALT_REG_EN
    do_reset();
    halt_reg = 64'h5;
    do_halt();
    halt_reg = '0;
    wait_done(200, n);
    chk("t7_err", 64'(err_count), 1);
    chk("t7_pass", 64'(pass), 0);
    chk("t7_fidx", 64'(first_err_idx), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
